// File: rtl/button_conditioner_if.sv
// Bundle of raw button inputs and conditioned outputs shared between the
// button conditioner and its consumer.
interface button_conditioner_if;
  logic [5:0] btn_n;
  logic [5:0] btn_level;
  logic [5:0] btn_press;
  logic [5:0] btn_release;
  logic       any_press;

  modport master (
    output btn_n,
    input  btn_level, btn_press, btn_release, any_press
  );

  modport slave (
    input  btn_n,
    output btn_level, btn_press, btn_release, any_press
  );
endinterface

// File: rtl/button_conditioner.sv
// Six independent synchronize-and-debounce channels for active-low buttons,
// producing a debounced level plus one-cycle press/release pulses.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                 clk_50M,
  input  logic                 rst,
  button_conditioner_if.slave  bus
);

  localparam logic [23:0] LIMIT = 24'(DEBOUNCE_CYCLES - 1);

  logic [5:0]  sync1_q, sync2_q;
  logic [5:0]  sync_act;
  logic [23:0] cnt_q [6];
  logic [23:0] cnt_d [6];
  logic [5:0]  level_q, level_d;
  logic [5:0]  press_q, press_d;
  logic [5:0]  release_q, release_d;
  logic        any_q, any_d;

  assign sync_act = ~sync2_q;

  always_comb begin
    level_d = level_q;
    for (int unsigned i = 0; i < 6; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync_act[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= LIMIT) begin
        level_d[i] = ~level_q[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 24'd1;
      end
    end
    // Pulses derive from next-state level so they coincide with the level edge.
    press_d   = level_d & ~level_q;
    release_d = ~level_d & level_q;
    any_d     = |press_d;
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      any_q     <= 1'b0;
      for (int unsigned i = 0; i < 6; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q   <= bus.btn_n;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      any_q     <= any_d;
      for (int unsigned i = 0; i < 6; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign bus.btn_level   = level_q;
  assign bus.btn_press   = press_q;
  assign bus.btn_release = release_q;
  assign bus.any_press   = any_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner with DEBOUNCE_CYCLES=4: expected
// pulses are queued with their due cycle when stimulus is driven.
module tb_button_conditioner;

  logic clk = 1'b0;
  logic rst = 1'b1;

  button_conditioner_if bus ();

  button_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .clk_50M (clk),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int unsigned cyc;
    logic [5:0]  press;
    logic [5:0]  rel;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [5:0]  lvl_exp = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Advance n edges; after each, compare every output against the scoreboard.
  task automatic step(input int unsigned n);
    exp_t       e;
    logic       rst_at_edge;
    logic [5:0] exp_p, exp_r;
    for (int unsigned k = 0; k < n; k++) begin
      rst_at_edge = rst;
      @(posedge clk);
      cyc++;
      #1;
      if (rst_at_edge) lvl_exp = '0;
      exp_p = '0;
      exp_r = '0;
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e     = sb.pop_front();
        exp_p = e.press;
        exp_r = e.rel;
      end
      lvl_exp = (lvl_exp | exp_p) & ~exp_r;
      chk("press",   32'(bus.btn_press),   32'(exp_p));
      chk("release", 32'(bus.btn_release), 32'(exp_r));
      chk("any",     32'(bus.any_press),   32'(|exp_p));
      chk("level",   32'(bus.btn_level),   32'(lvl_exp));
    end
  endtask

  task automatic expect_evt(input int unsigned dly, input logic [5:0] p, input logic [5:0] r);
    exp_t e;
    e.cyc   = cyc + dly;
    e.press = p;
    e.rel   = r;
    sb.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.btn_n = '1;
    rst = 1'b1;
    step(3);
    chk("rst_level", 32'(bus.btn_level), 32'h0);
    chk("rst_press", 32'(bus.btn_press), 32'h0);
    rst = 1'b0;
    step(3);

    // Clean press on ch0, long hold must not repeat, then release.
    bus.btn_n[0] = 1'b0;
    expect_evt(6, 6'b000001, 6'b000000);
    step(30);
    bus.btn_n[0] = 1'b1;
    expect_evt(6, 6'b000000, 6'b000001);
    step(10);

    // Bounce on ch2: three low samples are one short of acceptance.
    bus.btn_n[2] = 1'b0;
    step(3);
    bus.btn_n[2] = 1'b1;
    step(1);
    bus.btn_n[2] = 1'b0;
    expect_evt(6, 6'b000100, 6'b000000);
    step(10);
    bus.btn_n[2] = 1'b1;
    expect_evt(6, 6'b000000, 6'b000100);
    step(10);

    // ch4 long hold then release.
    bus.btn_n[4] = 1'b0;
    expect_evt(6, 6'b010000, 6'b000000);
    step(60);
    bus.btn_n[4] = 1'b1;
    expect_evt(6, 6'b000000, 6'b010000);
    step(10);

    // Simultaneous press and release of ch0/ch1.
    bus.btn_n[1:0] = 2'b00;
    expect_evt(6, 6'b000011, 6'b000000);
    step(10);
    bus.btn_n[1:0] = 2'b11;
    expect_evt(6, 6'b000000, 6'b000011);
    step(10);

    // ch5 held at level 1, ch0 mid-count (cnt=2) when reset hits.
    bus.btn_n[5] = 1'b0;
    expect_evt(6, 6'b100000, 6'b000000);
    step(10);
    bus.btn_n[0] = 1'b0;
    step(4);
    rst = 1'b1;
    step(1);
    chk("midrst_level",   32'(bus.btn_level),   32'h0);
    chk("midrst_release", 32'(bus.btn_release), 32'h0);
    step(1);
    rst = 1'b0;
    expect_evt(6, 6'b100001, 6'b000000);
    step(12);
    bus.btn_n = '1;
    expect_evt(6, 6'b000000, 6'b100001);
    step(10);

    chk("drain", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, meaning the count of consecutive stable synchronized samples needed to accept a level change (20 ms at 50 MHz); legal range 2 to 2^24-1.
REQ-002 The block SHALL have port clk_50M, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port btn_n, input, 6 bits: raw asynchronous buttons, active-low; bit0 player1, bit1 player2, bit2 start, bit3 reset, bit4 add, bit5 sub.
REQ-005 The block SHALL have port btn_level, output, 6 bits: debounced pressed state, active-high, registered.
REQ-006 The block SHALL have port btn_press, output, 6 bits: one-cycle pulse on each debounced press (level 0->1), registered.
REQ-007 The block SHALL have port btn_release, output, 6 bits: one-cycle pulse on each debounced release (level 1->0), registered.
REQ-008 The block SHALL have port any_press, output, 1 bit: registered OR of btn_press.

Function
REQ-009 Each of the 6 channels SHALL be processed independently and identically; no channel's behaviour SHALL depend on another's.
REQ-010 Each channel SHALL pass btn_n[i] through a 2-flop synchronizer before any other use; the synchronized value SHALL be inverted to active-high (sync_i).
REQ-011 Each channel SHALL hold a 24-bit stability counter cnt_i.
REQ-012 If sync_i equals btn_level[i], cnt_i SHALL be cleared to 0 on the next edge.
REQ-013 If sync_i differs from btn_level[i] and cnt_i < DEBOUNCE_CYCLES-1, cnt_i SHALL increment by 1.
REQ-014 If sync_i differs from btn_level[i] and cnt_i = DEBOUNCE_CYCLES-1, then on the next edge btn_level[i] SHALL toggle and cnt_i SHALL clear to 0.
REQ-015 A bounce (sync_i returning to btn_level[i] before the threshold) SHALL discard the partial count, so acceptance requires DEBOUNCE_CYCLES consecutive differing samples.
REQ-016 Latency without bounce SHALL be exact: numbering as edge 1 the first edge that samples the new raw value, btn_level[i] SHALL change at edge DEBOUNCE_CYCLES+2.
REQ-017 btn_press[i] SHALL be 1 for exactly the cycle in which btn_level[i] has just risen, and 0 otherwise.
REQ-018 btn_release[i] SHALL be 1 for exactly the cycle in which btn_level[i] has just fallen, and 0 otherwise.
REQ-019 A held button SHALL produce exactly one btn_press, with no repeat, regardless of hold duration.
REQ-020 any_press SHALL be asserted in the same cycle as any btn_press bit.
REQ-021 When several channels qualify in the same cycle, all corresponding btn_press bits SHALL assert together; priority among them belongs to the downstream FSM.
REQ-022 cnt_i SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.

Reset
REQ-023 While rst=1, both synchronizer flops SHALL load 1 (released), cnt_i SHALL be 0, and btn_level, btn_press, btn_release and any_press SHALL all be 0.
REQ-024 rst asserted mid-count or while a button is held SHALL discard all state; no press or release pulse SHALL be produced on entry to reset.
REQ-025 A button still held when rst deasserts SHALL be treated as a new press: it SHALL be accepted per REQ-016 and SHALL produce one btn_press.

Verification (DEBOUNCE_CYCLES=4)
REQ-026 Clean press: btn_n[0] driven 1->0 and held -> btn_level[0] rises at edge 6, and btn_press[0] and any_press are high for that one cycle only.
REQ-027 Bounce: btn_n[2] driven low for 3 cycles, high for 1, then low -> no press for the first burst; btn_level[2] rises 6 edges after the final fall.
REQ-028 Release: btn_n[4] released after a long hold -> one btn_release[4] pulse at edge 6 after release and no extra btn_press.
REQ-029 Simultaneous press: btn_n[0] and btn_n[1] fall on the same edge -> btn_press = 6'b000011 in a single cycle.
REQ-030 Reset mid-operation: rst pulsed while cnt_0=2, with btn_n[0] still held -> all outputs 0 during reset; btn_press[0] occurs 6 edges after rst falls.
